// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0000;
    localparam int PC_INC = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Power-of-two circular FIFO of fetched {pc, inst} entries with a synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, keeps one memory request in flight and
// buffers responses in a prefetch queue so decode stalls do not stop fetching.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    input  logic            im_busy_i,
    input  logic [XLEN-1:0] im_dout_i,
    output logic            im_req_o,
    output logic [XLEN-1:0] im_addr_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_valid_o,
    output logic            stall_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] last_pc;
    logic            outstanding;
    logic            drop;
    logic            resp;
    logic            accept;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occupancy;
    logic            full;
    logic            empty;
    fetch_entry_t    head;
    fetch_entry_t    wentry;

    assign resp      = outstanding && !im_busy_i;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding};

    // The in-flight request reserves a slot, so the queue can never overflow.
    assign im_req_o = !rst_i && !redirect_i && !drop
                      && (occupancy < OW'(DEPTH))
                      && (!outstanding || resp);
    assign im_addr_o = fetch_pc;
    assign accept    = im_req_o && !im_busy_i;

    assign push   = resp && !redirect_i && !drop && (!full || pop);
    assign pop    = !empty && !stall_i && !redirect_i;
    assign wentry = '{pc: req_pc, inst: im_dout_i};

    assign inst_valid_o = !empty;
    assign inst_o       = empty ? NOP_INST : head.inst;
    assign inst_pc_o    = empty ? last_pc : head.pc;
    assign stall_o      = empty && (outstanding || im_busy_i);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A redirect with the old response still in flight arms drop so that stale data is discarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            last_pc     <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (redirect_i)  fetch_pc <= redirect_pc_i;
            else if (accept) fetch_pc <= fetch_pc + XLEN'(PC_INC);

            if (accept) req_pc <= fetch_pc;

            if (accept)    outstanding <= 1'b1;
            else if (resp) outstanding <= 1'b0;

            if (redirect_i && outstanding && !resp) drop <= 1'b1;
            else if (resp)                          drop <= 1'b0;

            if (!empty) last_pc <= head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4) plus a randomised run on a DEPTH=2
// instance whose fetch PC wraps through zero.
module tb_fetch_queue;

    localparam logic [31:0] K    = 32'h5A5A_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFE0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        redirect1 = 1'b0, stall1 = 1'b0, busy1 = 1'b0;
    logic [31:0] redirect_pc1 = '0;
    logic [31:0] dout1, addr1, inst1, ipc1, pend1 = '0;
    logic        req1, valid1, stallo1;

    logic        stall2 = 1'b1, busy2 = 1'b1;
    logic [31:0] dout2, addr2, inst2, ipc2, pend2 = '0;
    logic        req2, valid2, stallo2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect1),
        .redirect_pc_i (redirect_pc1),
        .stall_i       (stall1),
        .im_busy_i     (busy1),
        .im_dout_i     (dout1),
        .im_req_o      (req1),
        .im_addr_o     (addr1),
        .inst_o        (inst1),
        .inst_pc_o     (ipc1),
        .inst_valid_o  (valid1),
        .stall_o       (stallo1)
    );

    fetch_queue #(.XLEN(32), .DEPTH(2), .RESET_PC(RPC2), .NOP_INST(NOP)) dut2 (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .stall_i       (stall2),
        .im_busy_i     (busy2),
        .im_dout_i     (dout2),
        .im_req_o      (req2),
        .im_addr_o     (addr2),
        .inst_o        (inst2),
        .inst_pc_o     (ipc2),
        .inst_valid_o  (valid2),
        .stall_o       (stallo2)
    );

    // Instruction memory model: data is a fixed function of the accepted address.
    always @(posedge clk) begin
        if (req1 && !busy1) pend1 <= addr1;
        if (req2 && !busy2) pend2 <= addr2;
    end
    assign dout1 = pend1 ^ K;
    assign dout2 = pend2 ^ K;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ K;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic st, input logic bz);
        redirect1    = rd;
        redirect_pc1 = rpc;
        stall1       = st;
        busy1        = bz;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int pops;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        $display("[TB] reset state");
        checkOutput("rst_req", {31'b0, req1}, 32'd0);
        checkOutput("rst_addr", addr1, 32'h0);
        checkOutput("rst_inst", inst1, NOP);
        checkOutput("rst_pc", ipc1, 32'h0);
        checkOutput("rst_valid", {31'b0, valid1}, 32'd0);
        checkOutput("rst_stall", {31'b0, stallo1}, 32'd0);
        checkOutput("rst_req2", {31'b0, req2}, 32'd0);

        $display("[TB] streaming");
        nextCycle(); rst = 1'b0; #1;
        checkOutput("c0_req", {31'b0, req1}, 32'd1);
        checkOutput("c0_addr", addr1, 32'h0);
        checkOutput("c0_valid", {31'b0, valid1}, 32'd0);
        nextCycle();
        checkOutput("c1_addr", addr1, 32'h4);
        checkOutput("c1_valid", {31'b0, valid1}, 32'd0);
        checkOutput("c1_stall", {31'b0, stallo1}, 32'd1);
        nextCycle();
        checkOutput("c2_valid", {31'b0, valid1}, 32'd1);
        checkOutput("c2_pc", ipc1, 32'h0);
        checkOutput("c2_inst", inst1, memData(32'h0));
        checkOutput("c2_addr", addr1, 32'h8);
        nextCycle();
        checkOutput("c3_pc", ipc1, 32'h4);

        $display("[TB] memory busy");
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b1); #1;
        checkOutput("c4_pc", ipc1, 32'h8);
        checkOutput("c4_req", {31'b0, req1}, 32'd0);
        nextCycle();
        checkOutput("c5_valid", {31'b0, valid1}, 32'd0);
        checkOutput("c5_inst", inst1, NOP);
        checkOutput("c5_stall", {31'b0, stallo1}, 32'd1);
        checkOutput("c5_addr", addr1, 32'h10);
        nextCycle();
        checkOutput("c6_addr", addr1, 32'h10);
        checkOutput("c6_stall", {31'b0, stallo1}, 32'd1);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0); #1;
        checkOutput("c7_valid", {31'b0, valid1}, 32'd0);
        checkOutput("c7_req", {31'b0, req1}, 32'd1);
        checkOutput("c7_addr", addr1, 32'h10);

        $display("[TB] decode stall");
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); #1;
        checkOutput("c8_valid", {31'b0, valid1}, 32'd1);
        checkOutput("c8_pc", ipc1, 32'hC);
        checkOutput("c8_inst", inst1, memData(32'hC));
        nextCycle();
        nextCycle();
        for (int i = 11; i <= 17; i++) begin
            nextCycle();
            checkOutput("full_req", {31'b0, req1}, 32'd0);
            checkOutput("full_head", ipc1, 32'hC);
        end
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0); #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) nextCycle();
            checkOutput("drain_valid", {31'b0, valid1}, 32'd1);
            checkOutput("drain_pc", ipc1, 32'hC + 32'(4 * i));
            checkOutput("drain_inst", inst1, memData(32'hC + 32'(4 * i)));
        end

        $display("[TB] redirect with late response");
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); #1;
        nextCycle(); applyStimulus(1'b1, 32'h100, 1'b1, 1'b1); #1;
        checkOutput("c25_req", {31'b0, req1}, 32'd0);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0); #1;
        checkOutput("c26_valid", {31'b0, valid1}, 32'd0);
        checkOutput("c26_inst", inst1, NOP);
        checkOutput("c26_req", {31'b0, req1}, 32'd0);
        checkOutput("c26_addr", addr1, 32'h100);
        checkOutput("c26_holdpc", ipc1, 32'h24);
        checkOutput("c26_stall", {31'b0, stallo1}, 32'd1);
        nextCycle();
        checkOutput("c27_req", {31'b0, req1}, 32'd1);
        checkOutput("c27_addr", addr1, 32'h100);
        checkOutput("c27_valid", {31'b0, valid1}, 32'd0);
        nextCycle();
        checkOutput("c28_valid", {31'b0, valid1}, 32'd0);

        $display("[TB] redirect with coinciding response");
        nextCycle(); applyStimulus(1'b1, 32'h100, 1'b1, 1'b0); #1;
        checkOutput("c29_valid", {31'b0, valid1}, 32'd1);
        checkOutput("c29_pc", ipc1, 32'h100);
        checkOutput("c29_req", {31'b0, req1}, 32'd0);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0); #1;
        checkOutput("c30_valid", {31'b0, valid1}, 32'd0);
        checkOutput("c30_req", {31'b0, req1}, 32'd1);
        checkOutput("c30_addr", addr1, 32'h100);
        checkOutput("c30_stall", {31'b0, stallo1}, 32'd0);
        nextCycle();
        checkOutput("c31_valid", {31'b0, valid1}, 32'd0);
        nextCycle();
        checkOutput("c32_valid", {31'b0, valid1}, 32'd1);
        checkOutput("c32_pc", ipc1, 32'h100);
        checkOutput("c32_inst", inst1, memData(32'h100));

        $display("[TB] DEPTH=2 random run");
        exp_pc = RPC2;
        pops   = 0;
        for (int i = 0; i < 300; i++) begin
            nextCycle();
            busy2  = ($urandom_range(0, 3) == 0);
            stall2 = ($urandom_range(0, 2) == 0);
            #1;
            if (valid2 && !stall2) begin
                checkOutput("rand_pc", ipc2, exp_pc);
                checkOutput("rand_inst", inst2, memData(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        checkOutput("rand_enough", {31'b0, pops >= 20}, 32'd1);
        checkOutput("rand_wrapped", {31'b0, exp_pc < 32'h1000}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
